bresenham_line_stepper: RTL and testbench

//  Sequential Bresenham pixel generator; sits directly downstream of the steep-swap stage.
//  - Accepts one line command: endpoints already steep-swapped, plus the steep flag.
//  - Orders the endpoints so that x0<=x1, then emits one pixel per cycle under a valid/ready handshake.
//  - Undoes the steep swap on output, so pixels are in screen coordinates for the raster/frame-buffer writer.

---
 rtl/bresenham_line_stepper_if.sv | 29 ++
 rtl/bresenham_line_stepper.sv | 136 +++++++++++++
 tb/tb_bresenham_line_stepper.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bresenham_line_stepper_if.sv
// Line-command and pixel-stream handshake bundle for the Bresenham stepper.
// The slave side is the stepper; the master side issues commands and sinks pixels.
interface bresenham_line_stepper_if #(
    parameter int WIDTH = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    steep;
    logic signed [WIDTH-1:0] x0;
    logic signed [WIDTH-1:0] y0;
    logic signed [WIDTH-1:0] x1;
    logic signed [WIDTH-1:0] y1;
    logic                    pix_valid;
    logic                    pix_ready;
    logic signed [WIDTH-1:0] pix_x;
    logic signed [WIDTH-1:0] pix_y;
    logic                    busy;
    logic                    done;

    modport master (
        output in_valid, steep, x0, y0, x1, y1, pix_ready,
        input  in_ready, pix_valid, pix_x, pix_y, busy, done
    );

    modport slave (
        input  in_valid, steep, x0, y0, x1, y1, pix_ready,
        output in_ready, pix_valid, pix_x, pix_y, busy, done
    );
endinterface

// File: rtl/bresenham_line_stepper.sv
// Sequential Bresenham pixel generator: takes one steep-swapped line command and
// emits its pixels in screen space, one per cycle, under a valid/ready handshake.
module bresenham_line_stepper #(
    parameter int WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bresenham_line_stepper_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } state_t;

    localparam logic signed [WIDTH-1:0] step_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t next_state;

    logic                    steep_q;
    logic                    ystep_up;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] xe;
    logic signed [WIDTH-1:0] ye;
    logic signed [WIDTH:0]   dx;
    logic signed [WIDTH:0]   dy;
    logic signed [WIDTH:0]   err;

    logic                    swap;
    logic                    advance;
    logic signed [WIDTH:0]   x_ext;
    logic signed [WIDTH:0]   y_ext;
    logic signed [WIDTH:0]   xe_ext;
    logic signed [WIDTH:0]   ye_ext;
    logic signed [WIDTH:0]   dx_new;
    logic signed [WIDTH:0]   dy_raw;
    logic signed [WIDTH:0]   err_sub;

    // Spans are formed one bit wider so a full-range line cannot overflow.
    assign swap    = bus.x0 > bus.x1;
    assign x_ext   = {x[WIDTH-1], x};
    assign y_ext   = {y[WIDTH-1], y};
    assign xe_ext  = {xe[WIDTH-1], xe};
    assign ye_ext  = {ye[WIDTH-1], ye};
    assign dx_new  = xe_ext - x_ext;
    assign dy_raw  = ye_ext - y_ext;
    assign err_sub = err - dy;
    assign advance = (state == RUN) && bus.pix_ready && (x != xe);

    assign bus.pix_x = steep_q ? y : x;
    assign bus.pix_y = steep_q ? x : y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.pix_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = RUN;
            end
            RUN: begin
                bus.pix_valid = 1'b1;
                if (bus.pix_ready && (x == xe)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Endpoints are ordered on acceptance so stepping always runs with x ascending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steep_q  <= 1'b0;
            ystep_up <= 1'b0;
            x        <= '0;
            y        <= '0;
            xe       <= '0;
            ye       <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                steep_q <= bus.steep;
                x       <= swap ? bus.x1 : bus.x0;
                y       <= swap ? bus.y1 : bus.y0;
                xe      <= swap ? bus.x0 : bus.x1;
                ye      <= swap ? bus.y0 : bus.y1;
            end
            if (state == SETUP) begin
                dx       <= dx_new;
                dy       <= (dy_raw < 0) ? -dy_raw : dy_raw;
                err      <= dx_new >>> 1;
                ystep_up <= y < ye;
            end
            if (advance) begin
                x <= x + step_one;
                if (err_sub < 0) begin
                    y   <= ystep_up ? (y + step_one) : (y - step_one);
                    err <= err_sub + dx;
                end else begin
                    err <= err_sub;
                end
            end
        end
    end

endmodule

// File: tb/tb_bresenham_line_stepper.sv
// Bench for bresenham_line_stepper: directed line table, randomized lines checked
// against a closed-form pixel model, and a stall / mid-line reset sequence.
module tb_bresenham_line_stepper;

    localparam int WIDTH = 10;

    typedef struct packed {
        logic signed [15:0]      x0;
        logic signed [15:0]      y0;
        logic signed [15:0]      x1;
        logic signed [15:0]      y1;
        logic                    steep;
        logic [3:0]              n;
        logic signed [0:5][15:0] ex;
        logic signed [0:5][15:0] ey;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_x[$];
    int   exp_y[$];
    vec_t tbl[5];

    bresenham_line_stepper_if #(.WIDTH(WIDTH)) bus ();

    bresenham_line_stepper #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input int a0, input int b0,
                                 input int a1, input int b1, input bit st);
        bus.in_valid = v;
        bus.x0       = WIDTH'(a0);
        bus.y0       = WIDTH'(b0);
        bus.x1       = WIDTH'(a1);
        bus.y1       = WIDTH'(b1);
        bus.steep    = st;
    endtask

    function automatic logic signed [0:5][15:0] p6(input int a, input int b, input int c,
                                                    input int d, input int e, input int f);
        return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f)};
    endfunction

    // Pixel i of the ordered line sits k_i rows off the start, where k_i is the
    // smallest count keeping the running error (dx/2 - i*dy + k*dx) non-negative.
    task automatic build_expected(input int ax0, input int ay0, input int ax1, input int ay1,
                                  input bit st);
        int sx0, sy0, sx1, sy1, ddx, ddy, h, s, k, xx, yy;
        sx0 = ax0; sy0 = ay0; sx1 = ax1; sy1 = ay1;
        if (ax0 > ax1) begin
            sx0 = ax1; sy0 = ay1; sx1 = ax0; sy1 = ay0;
        end
        ddx = sx1 - sx0;
        ddy = (sy1 > sy0) ? sy1 - sy0 : sy0 - sy1;
        h   = ddx / 2;
        s   = (sy0 < sy1) ? 1 : -1;
        exp_x.delete();
        exp_y.delete();
        for (int i = 0; i <= ddx; i++) begin
            k  = (ddx == 0) ? 0 : (i * ddy - h + ddx - 1) / ddx;
            xx = sx0 + i;
            yy = sy0 + s * k;
            exp_x.push_back(st ? yy : xx);
            exp_y.push_back(st ? xx : yy);
        end
    endtask

    // Drives one command, keeps a foreign command on in_valid while busy, and
    // walks the pixel stream with optional random back-pressure.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit st, input bit stall, input string tag);
        int n;
        int stalls;
        n = exp_x.size();
        bus.pix_ready = 1'b1;
        applyStimulus(1'b1, ax0, ay0, ax1, ay1, st);
        checkOutput({tag, " idle in_ready"}, int'(bus.in_ready), 1);
        checkOutput({tag, " idle busy"}, int'(bus.busy), 0);
        @(posedge clk); #1;
        applyStimulus(1'b1, int'($urandom_range(0, 300)), int'($urandom_range(0, 300)),
                      int'($urandom_range(0, 300)), int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
        checkOutput({tag, " setup pix_valid"}, int'(bus.pix_valid), 0);
        checkOutput({tag, " setup in_ready"}, int'(bus.in_ready), 0);
        checkOutput({tag, " setup busy"}, int'(bus.busy), 1);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            bit rdy;
            stalls = 0;
            do begin
                rdy = (stall && stalls < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.pix_ready = rdy;
                checkOutput($sformatf("%s pix%0d valid", tag, i), int'(bus.pix_valid), 1);
                checkOutput($sformatf("%s pix%0d x", tag, i), int'(bus.pix_x), exp_x[i]);
                checkOutput($sformatf("%s pix%0d y", tag, i), int'(bus.pix_y), exp_y[i]);
                checkOutput($sformatf("%s pix%0d done", tag, i), int'(bus.done), 0);
                @(posedge clk); #1;
                if (!rdy) stalls++;
            end while (!rdy);
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, " done pulse"}, int'(bus.done), 1);
        checkOutput({tag, " done pix_valid"}, int'(bus.pix_valid), 0);
        checkOutput({tag, " done busy"}, int'(bus.busy), 1);
        @(posedge clk); #1;
        checkOutput({tag, " after done"}, int'(bus.done), 0);
        checkOutput({tag, " after busy"}, int'(bus.busy), 0);
        checkOutput({tag, " after in_ready"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int ax0, ay0, ax1, ay1, ldx, ldy;
        bit st;
        checks = 0;
        errors = 0;

        tbl[0] = '{16'sd0, 16'sd0, 16'sd5, 16'sd2, 1'b0, 4'd6, p6(0, 1, 2, 3, 4, 5), p6(0, 0, 1, 1, 2, 2)};
        tbl[1] = '{16'sd5, 16'sd2, 16'sd0, 16'sd0, 1'b0, 4'd6, p6(0, 1, 2, 3, 4, 5), p6(0, 0, 1, 1, 2, 2)};
        tbl[2] = '{16'sd0, 16'sd0, 16'sd5, 16'sd2, 1'b1, 4'd6, p6(0, 0, 1, 1, 2, 2), p6(0, 1, 2, 3, 4, 5)};
        tbl[3] = '{16'sd0, 16'sd3, 16'sd3, 16'sd0, 1'b0, 4'd4, p6(0, 1, 2, 3, 0, 0), p6(3, 2, 1, 0, 0, 0)};
        tbl[4] = '{16'sd7, 16'sd7, 16'sd7, 16'sd7, 1'b0, 4'd1, p6(7, 0, 0, 0, 0, 0), p6(7, 0, 0, 0, 0, 0)};

        rst_n         = 1'b1;
        bus.pix_ready = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", int'(bus.in_ready), 1);
        checkOutput("reset pix_valid", int'(bus.pix_valid), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset pix_x", int'(bus.pix_x), 0);
        checkOutput("reset pix_y", int'(bus.pix_y), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) begin
            exp_x.delete();
            exp_y.delete();
            for (int j = 0; j < int'(tbl[k].n); j++) begin
                exp_x.push_back(int'(tbl[k].ex[j]));
                exp_y.push_back(int'(tbl[k].ey[j]));
            end
            run_line(int'(tbl[k].x0), int'(tbl[k].y0), int'(tbl[k].x1), int'(tbl[k].y1),
                     tbl[k].steep, 1'b0, $sformatf("table%0d", k));
        end

        build_expected(511, 511, -512, -512, 1'b1);
        run_line(511, 511, -512, -512, 1'b1, 1'b0, "fullrange");

        for (int r = 0; r < 30; r++) begin
            ldx = int'($urandom_range(0, 40));
            ldy = int'($urandom_range(0, ldx));
            ax0 = int'($urandom_range(0, 400)) - 200;
            ay0 = int'($urandom_range(0, 400)) - 200;
            ax1 = $urandom_range(0, 1) ? ax0 + ldx : ax0 - ldx;
            ay1 = $urandom_range(0, 1) ? ay0 + ldy : ay0 - ldy;
            st  = 1'($urandom_range(0, 1));
            build_expected(ax0, ay0, ax1, ay1, st);
            run_line(ax0, ay0, ax1, ay1, st, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        // Back-pressure on the third pixel, then reset while the fourth is offered.
        bus.pix_ready = 1'b1;
        applyStimulus(1'b1, 0, 0, 5, 2, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        checkOutput("stall pix0 x", int'(bus.pix_x), 0);
        checkOutput("stall pix0 y", int'(bus.pix_y), 0);
        @(posedge clk); #1;
        checkOutput("stall pix1 x", int'(bus.pix_x), 1);
        checkOutput("stall pix1 y", int'(bus.pix_y), 0);
        @(posedge clk); #1;
        bus.pix_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("stall hold%0d valid", c), int'(bus.pix_valid), 1);
            checkOutput($sformatf("stall hold%0d x", c), int'(bus.pix_x), 2);
            checkOutput($sformatf("stall hold%0d y", c), int'(bus.pix_y), 1);
            @(posedge clk); #1;
        end
        bus.pix_ready = 1'b1;
        checkOutput("stall pix2 x", int'(bus.pix_x), 2);
        checkOutput("stall pix2 y", int'(bus.pix_y), 1);
        @(posedge clk); #1;
        checkOutput("stall pix3 x", int'(bus.pix_x), 3);
        checkOutput("stall pix3 y", int'(bus.pix_y), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset pix_valid", int'(bus.pix_valid), 0);
        checkOutput("midreset in_ready", int'(bus.in_ready), 1);
        checkOutput("midreset busy", int'(bus.busy), 0);
        checkOutput("midreset done", int'(bus.done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("postreset%0d done", c), int'(bus.done), 0);
            checkOutput($sformatf("postreset%0d pix_valid", c), int'(bus.pix_valid), 0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
